tm1638_target: RTL

Device-side model of the TM1638 LED/key controller serial interface. It responds to a host driving strobe, clock and data. It decodes data, address and display-control commands, holds the 16-byte display RAM and returns 4 bytes of key-scan data. It is used as the bus partner of the host serial shifter, both in benches and as an on-FPGA display emulator feeding a local LED/7-segment driver.

---
 rtl/tm1638_pkg.sv | 27 ++
 rtl/tm1638_sync_edge.sv | 38 +++
 rtl/tm1638_target.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 target: command classes, data-command bit
// positions, frame state encoding and display RAM geometry.
package tm1638_pkg;

  localparam logic [1:0] CLS_DATA    = 2'b01;
  localparam logic [1:0] CLS_DISPCTL = 2'b10;
  localparam logic [1:0] CLS_ADDR    = 2'b11;

  localparam int DC_READ_BIT  = 1;
  localparam int DC_FIXED_BIT = 2;

  localparam int RAM_DEPTH = 16;
  localparam int RAM_AW    = 4;
  localparam int KEY_BITS  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  function automatic logic [1:0] cmd_class(input logic [7:0] b);
    return b[7:6];
  endfunction

endpackage

// File: rtl/tm1638_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module tm1638_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/tm1638_target.sv
// Device-side TM1638 serial target: command decode, 16-byte display RAM and
// key-scan readback. Read mode is built only when TM1638_KEYSCAN_EN is defined.
module tm1638_target
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stb,
  input  logic                sclk,
  input  logic                dio_in,
  output logic                dio_out,
  output logic                dio_oe,
  input  logic [KEY_BITS-1:0] keys,
  input  logic [RAM_AW-1:0]   disp_addr,
  output logic [7:0]          disp_data,
  output logic                disp_on,
  output logic [2:0]          brightness,
  output logic                cmd_valid
);

  logic stb_lvl, stb_rise, stb_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic din_lvl, din_rise_unused, din_fall_unused;

  tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stb (
    .clk(clk), .rst(rst), .d(stb),
    .level(stb_lvl), .rise(stb_rise), .fall(stb_fall)
  );

  tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .rst(rst), .d(dio_in),
    .level(din_lvl), .rise(din_rise_unused), .fall(din_fall_unused)
  );

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_done_q, byte_done_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic              read_mode_q, read_mode_d;
  logic              fixed_q, fixed_d;
  logic [7:0]        ram_q [RAM_DEPTH];
  logic [7:0]        ram_d [RAM_DEPTH];
  logic [7:0]        disp_data_q, disp_data_d;
  logic              disp_on_q, disp_on_d;
  logic [2:0]        brightness_q, brightness_d;
  logic              cmd_valid_q, cmd_valid_d;
`ifdef TM1638_KEYSCAN_EN
  logic [KEY_BITS-1:0] key_snap_q, key_snap_d;
  logic [5:0]          rd_idx_q, rd_idx_d;
  logic                dio_out_q, dio_out_d;
  logic                dio_oe_q, dio_oe_d;
`endif

  logic unused_inputs;
  assign unused_inputs = sclk_lvl ^ stb_lvl
`ifndef TM1638_KEYSCAN_EN
                         ^ sclk_fall ^ (^keys)
`endif
                         ;

  // NOTE: every always_comb output gets a default before any branch so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_done_d  = 1'b0;
    addr_d       = addr_q;
    read_mode_d  = read_mode_q;
    fixed_d      = fixed_q;
    ram_d        = ram_q;
    disp_data_d  = ram_q[disp_addr];
    disp_on_d    = disp_on_q;
    brightness_d = brightness_q;
    cmd_valid_d  = 1'b0;
`ifdef TM1638_KEYSCAN_EN
    key_snap_d   = key_snap_q;
    rd_idx_d     = rd_idx_q;
    dio_out_d    = dio_out_q;
    dio_oe_d     = dio_oe_q;
`endif

    if (stb_rise) begin
      // Abort: any partial byte or pending decode is discarded.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
`ifdef TM1638_KEYSCAN_EN
      dio_oe_d  = 1'b0;
      dio_out_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = '0;
`ifdef TM1638_KEYSCAN_EN
          dio_oe_d  = 1'b0;
`endif
          if (stb_fall) state_d = ST_CMD;
        end

        ST_CMD, ST_WDATA: begin
          if (sclk_rise) begin
            shift_d     = {din_lvl, shift_q[7:1]};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end
          if (byte_done_q && state_q == ST_CMD) begin
            cmd_valid_d = 1'b1;
            state_d     = ST_IDLE;
            case (cmd_class(shift_q))
              CLS_DATA: begin
                if (!shift_q[DC_READ_BIT]) begin
                  read_mode_d = 1'b0;
                  fixed_d     = shift_q[DC_FIXED_BIT];
                end
`ifdef TM1638_KEYSCAN_EN
                else begin
                  read_mode_d = 1'b1;
                  fixed_d     = shift_q[DC_FIXED_BIT];
                  key_snap_d  = keys;
                  rd_idx_d    = '0;
                  state_d     = ST_RDATA;
                end
`endif
              end
              CLS_ADDR: begin
                addr_d  = shift_q[RAM_AW-1:0];
                state_d = ST_WDATA;
              end
              CLS_DISPCTL: begin
                disp_on_d    = shift_q[3];
                brightness_d = shift_q[2:0];
              end
              default: ;
            endcase
          end else if (byte_done_q && !read_mode_q) begin
            ram_d[addr_q] = shift_q;
            if (!fixed_q) addr_d = addr_q + 1'b1;
          end
        end

`ifdef TM1638_KEYSCAN_EN
        ST_RDATA: begin
          if (sclk_fall) begin
            dio_oe_d  = 1'b1;
            dio_out_d = (rd_idx_q < 6'd32) ? key_snap_q[rd_idx_q[4:0]] : 1'b0;
            if (rd_idx_q != 6'd32) rd_idx_d = rd_idx_q + 6'd1;
          end
        end
`endif

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: the display RAM is small and must read back as zero after reset, so
  // it is built from resettable flops rather than an inferred memory block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_done_q  <= 1'b0;
      addr_q       <= '0;
      read_mode_q  <= 1'b0;
      fixed_q      <= 1'b0;
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= '0;
      disp_data_q  <= '0;
      disp_on_q    <= 1'b0;
      brightness_q <= '0;
      cmd_valid_q  <= 1'b0;
`ifdef TM1638_KEYSCAN_EN
      key_snap_q   <= '0;
      rd_idx_q     <= '0;
      dio_out_q    <= 1'b0;
      dio_oe_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_done_q  <= byte_done_d;
      addr_q       <= addr_d;
      read_mode_q  <= read_mode_d;
      fixed_q      <= fixed_d;
      ram_q        <= ram_d;
      disp_data_q  <= disp_data_d;
      disp_on_q    <= disp_on_d;
      brightness_q <= brightness_d;
      cmd_valid_q  <= cmd_valid_d;
`ifdef TM1638_KEYSCAN_EN
      key_snap_q   <= key_snap_d;
      rd_idx_q     <= rd_idx_d;
      dio_out_q    <= dio_out_d;
      dio_oe_q     <= dio_oe_d;
`endif
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_on    = disp_on_q;
  assign brightness = brightness_q;
  assign cmd_valid  = cmd_valid_q;
`ifdef TM1638_KEYSCAN_EN
  assign dio_out    = dio_out_q;
  assign dio_oe     = dio_oe_q;
`else
  assign dio_out    = 1'b0;
  assign dio_oe     = 1'b0;
`endif

endmodule
